// File: rtl/divide_vector_scheduler.sv
// divide_vector_scheduler: streams an N-element vector through one shared
// in-order pipelined divider and gathers the quotients back into a vector.
module divide_vector_scheduler #(
  parameter int BITS = 16,
  parameter int N    = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a [N],
  input  logic [BITS-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] c [N],
  output logic            div_in_valid,
  output logic [BITS-1:0] div_a,
  output logic [BITS-1:0] div_b,
  input  logic            div_out_valid,
  input  logic [BITS-1:0] div_c,
  output logic            err
);

  localparam int CW = $clog2(N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] FULL = CW'(N);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_d;

  logic [BITS-1:0] a_reg [N];
  logic [BITS-1:0] c_reg [N];
  logic [BITS-1:0] b_reg;
  logic [CW-1:0]   iss, rcv;
  logic [CW-1:0]   iss_nxt;
  logic [IW-1:0]   iss_idx, rcv_idx;
  logic            accept, collect;
  logic            stray, rcv_done;

  assign accept   = in_valid && (state == IDLE);
  assign collect  = div_out_valid && rcv != FULL &&
                    (state == ISSUE || state == WAIT);
  assign stray    = div_out_valid && !collect;
  assign rcv_done = (rcv == FULL) ||
                    (collect && rcv == LAST);
  assign iss_nxt  = iss + CW'(1);
  assign iss_idx  = iss_nxt[IW-1:0];
  assign rcv_idx  = rcv[IW-1:0];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign c         = c_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (in_valid) state_d = ISSUE;
      end
      ISSUE: begin
        if (iss == LAST) begin
          state_d = rcv_done ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (rcv_done) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // iss is the index currently presented on div_a
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      iss          <= '0;
      rcv          <= '0;
      b_reg        <= '0;
      div_in_valid <= 1'b0;
      div_a        <= '0;
      div_b        <= '0;
      err          <= 1'b0;
      for (int i = 0; i < N; i++) begin
        a_reg[i] <= '0;
        c_reg[i] <= '0;
      end
    end else begin
      if (stray) err <= 1'b1;
      if (collect) begin
        c_reg[rcv_idx] <= div_c;
        rcv            <= rcv + CW'(1);
      end
      if (accept) begin
        for (int i = 0; i < N; i++) begin
          a_reg[i] <= a[i];
        end
        b_reg        <= b;
        iss          <= '0;
        rcv          <= '0;
        div_in_valid <= 1'b1;
        div_a        <= a[0];
        div_b        <= b;
      end
      if (state == ISSUE) begin
        if (iss == LAST) begin
          div_in_valid <= 1'b0;
          div_a        <= '0;
          div_b        <= '0;
        end else begin
          iss   <= iss_nxt;
          div_a <= a_reg[iss_idx];
          div_b <= b_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_divide_vector_scheduler.sv
// tb_divide_vector_scheduler: random and directed ops against a
// half-precision divider model, for N=3/L=5 and N=1/L=1.
module tb_divide_vector_scheduler;

  localparam int N = 3;
  localparam int L = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready;
  logic        out_valid, out_ready, err;
  logic [15:0] a [N];
  logic [15:0] c [N];
  logic [15:0] b;
  logic        div_in_valid, div_out_valid;
  logic [15:0] div_a, div_b, div_c;
  logic        spur;

  logic        in_valid1, in_ready1;
  logic        out_valid1, out_ready1, err1;
  logic [15:0] a1 [1];
  logic [15:0] c1 [1];
  logic [15:0] b1;
  logic        div_in_valid1, div_out_valid1;
  logic [15:0] div_a1, div_b1, div_c1;

  int checks = 0;
  int errors = 0;
  bit exp_err = 1'b0;

  logic [15:0] va [N];
  logic [15:0] vb;
  logic [15:0] expc [N];
  logic [15:0] cap [N];

  divide_vector_scheduler #(.BITS(16), .N(N)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c),
    .div_in_valid(div_in_valid),
    .div_a(div_a), .div_b(div_b),
    .div_out_valid(div_out_valid), .div_c(div_c),
    .err(err)
  );

  divide_vector_scheduler #(.BITS(16), .N(1)) dut1 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .c(c1),
    .div_in_valid(div_in_valid1),
    .div_a(div_a1), .div_b(div_b1),
    .div_out_valid(div_out_valid1), .div_c(div_c1),
    .err(err1)
  );

  // half-precision divide of normal numbers, truncating
  function automatic logic [15:0] hdiv(
    input logic [15:0] x, input logic [15:0] y);
    int e;
    int unsigned ma, mb, q;
    ma = 1024 + int'(x[9:0]);
    mb = 1024 + int'(y[9:0]);
    q = (ma << 11) / mb;
    if (q >= 2048) begin
      q = q >> 1;
      e = int'(x[14:10]) - int'(y[14:10]) + 15;
    end else begin
      e = int'(x[14:10]) - int'(y[14:10]) + 14;
    end
    return {x[15] ^ y[15], e[4:0], q[9:0]};
  endfunction

  function automatic logic [15:0] rand_half();
    logic [4:0] ex;
    ex = 5'($urandom_range(20, 10));
    return {1'($urandom), ex, 10'($urandom)};
  endfunction

  logic        pv [L];
  logic [15:0] pd [L];
  logic        p1v;
  logic [15:0] p1d;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < L; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
      p1v <= 1'b0;
      p1d <= '0;
    end else begin
      pv[0] <= div_in_valid;
      pd[0] <= hdiv(div_a, div_b);
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      p1v <= div_in_valid1;
      p1d <= hdiv(div_a1, div_b1);
    end
  end

  assign div_out_valid  = pv[L-1] | spur;
  assign div_c          = spur ? 16'hdead : pd[L-1];
  assign div_out_valid1 = p1v;
  assign div_c1         = p1d;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  // call at a negedge; returns at a negedge with DUT idle
  task automatic run_op(input int hold, input bit keep);
    int k, n_iss, first, last, lat;
    for (int i = 0; i < N; i++) begin
      expc[i] = hdiv(va[i], vb);
      a[i] = va[i];
    end
    b = vb;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) a[i] = 16'($urandom);
    b = 16'($urandom);
    n_iss = 0;
    first = 0;
    last = 0;
    lat = 0;
    for (k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (div_in_valid) begin
        n_iss++;
        if (first == 0) first = k;
        last = k;
      end
      if (out_valid) lat = k;
    end
    check("issue_count", 32'(n_iss), N);
    check("issue_first", 32'(first), 1);
    check("issue_last", 32'(last), N);
    check("out_latency", 32'(lat), N + L + 1);
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 1);
      check("hold_ready", 32'(in_ready), 0);
      for (int i = 0; i < N; i++)
        check("hold_c", 32'(c[i]), 32'(expc[i]));
    end
    for (int i = 0; i < N; i++) begin
      cap[i] = c[i];
      check($sformatf("c[%0d]", i), 32'(c[i]),
            32'(expc[i]));
    end
    check("err", 32'(err), 32'(exp_err));
    in_valid = keep;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rel_valid", 32'(out_valid), 0);
    check("rel_ready", 32'(in_ready), 1);
  endtask

  initial begin
    int k, n_iss, lat;
    in_valid = 0;
    out_ready = 0;
    b = 0;
    spur = 0;
    for (int i = 0; i < N; i++) a[i] = '0;
    in_valid1 = 0;
    out_ready1 = 0;
    a1[0] = '0;
    b1 = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_div_valid", 32'(div_in_valid), 0);
    check("rst_div_a", 32'(div_a), 0);
    check("rst_div_b", 32'(div_b), 0);
    check("rst_err", 32'(err), 0);
    for (int i = 0; i < N; i++) check("rst_c", 32'(c[i]), 0);
    rstn = 1'b1;
    @(negedge clk);

    va = '{16'h4000, 16'h4400, 16'h4800};
    vb = 16'h4000;
    run_op(10, 1'b1);
    check("dir1_c0", 32'(cap[0]), 32'h3c00);
    check("dir1_c1", 32'(cap[1]), 32'h4000);
    check("dir1_c2", 32'(cap[2]), 32'h4400);

    va = '{16'h4600, 16'h4600, 16'h4600};
    vb = 16'h4200;
    run_op(2, 1'b0);
    for (int i = 0; i < N; i++)
      check("dir2_c", 32'(cap[i]), 32'h4000);

    a1[0] = 16'h4400;
    b1 = 16'h4000;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    n_iss = 0;
    lat = 0;
    for (k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (div_in_valid1) n_iss++;
      if (out_valid1) lat = k;
    end
    check("n1_issue", 32'(n_iss), 1);
    check("n1_latency", 32'(lat), 3);
    check("n1_c", 32'(c1[0]), 32'h4000);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check("n1_rel_valid", 32'(out_valid1), 0);
    check("n1_err", 32'(err1), 0);

    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    exp_err = 1'b1;
    check("spur_err", 32'(err), 1);
    for (int i = 0; i < N; i++)
      check("spur_c", 32'(c[i]), 32'(expc[i]));
    @(negedge clk);
    check("spur_sticky", 32'(err), 1);
    for (int i = 0; i < N; i++) va[i] = rand_half();
    vb = rand_half();
    run_op(1, 1'b0);

    for (int i = 0; i < N; i++) a[i] = rand_half();
    b = rand_half();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_busy", 32'(in_ready), 0);
    rstn = 1'b0;
    #1;
    exp_err = 1'b0;
    check("mid_in_ready", 32'(in_ready), 1);
    check("mid_out_valid", 32'(out_valid), 0);
    check("mid_div_valid", 32'(div_in_valid), 0);
    check("mid_div_a", 32'(div_a), 0);
    check("mid_div_b", 32'(div_b), 0);
    check("mid_err", 32'(err), 0);
    for (int i = 0; i < N; i++) check("mid_c", 32'(c[i]), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) va[i] = rand_half();
    vb = rand_half();
    run_op(0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) va[i] = rand_half();
      vb = rand_half();
      run_op(int'($urandom_range(3, 0)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
